video_timing_gen: RTL and testbench

- Display timing generator that sits directly downstream of the APB timing-register block.
- Consumes the programmed CLKDIV, HDP, HNDP, VDP and VNDP values and produces a pixel-rate enable, horizontal/vertical counters, HSYNC, VSYNC, DE and a frame-end strobe for the pixel pipeline.
- Programmed values are shadowed and take effect only at frame boundaries, so register writes never tear a frame.

---
 rtl/video_timing_gen_if.sv | 30 +++
 rtl/video_timing_gen.sv | 120 ++++++++++++
 tb/tb_video_timing_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Configuration and timing-output bundle between the timing generator and its neighbours.
// The master side programs the timing values; the slave side is the generator itself.
interface video_timing_gen_if #(
  parameter int CW = 12,
  parameter int DW = 8
);
  logic          EN;
  logic [DW-1:0] CLKDIV;
  logic [CW-1:0] HDP;
  logic [CW-1:0] HNDP;
  logic [CW-1:0] VDP;
  logic [CW-1:0] VNDP;
  logic          PTICK;
  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic          DE;
  logic          HSYNC;
  logic          VSYNC;
  logic          FEND;

  modport master (
    output EN, CLKDIV, HDP, HNDP, VDP, VNDP,
    input  PTICK, HCNT, VCNT, DE, HSYNC, VSYNC, FEND
  );

  modport slave (
    input  EN, CLKDIV, HDP, HNDP, VDP, VNDP,
    output PTICK, HCNT, VCNT, DE, HSYNC, VSYNC, FEND
  );
endinterface

// File: rtl/video_timing_gen.sv
// Display timing generator: pixel divider, H/V counters and registered sync/DE/frame-end decodes.
// Timing values are shadowed on enable and at each frame end so a frame never mixes settings.
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int DW       = 8,
  parameter int HSW      = 4,
  parameter int VSW      = 2,
  parameter int SYNC_POL = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  video_timing_gen_if.slave bus
);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);
  localparam logic [CW:0]   HSW_W    = (CW+1)'(HSW);
  localparam logic [CW:0]   VSW_W    = (CW+1)'(VSW);

  logic          active;
  logic [DW-1:0] div, s_clkdiv;
  logic [CW-1:0] s_hdp, s_hndp, s_vdp, s_vndp;
  logic [CW-1:0] hcnt, vcnt;
  logic          ptick, le, vlast, de, hsync, vsync, fend;

  logic [DW-1:0] div_n, s_clkdiv_n;
  logic [CW-1:0] s_hdp_n, s_hndp_n, s_vdp_n, s_vndp_n;
  logic [CW-1:0] hcnt_n, vcnt_n;
  logic [CW:0]   htot_n, vtot_n, hsw_n, vsw_n;
  logic          ptick_n, le_n, vlast_n, de_n, hs_n, vs_n, fend_n;

  // Next-state: everything below is computed from post-edge counters and shadows,
  // so the registered decodes line up with the HCNT/VCNT they describe.
  always_comb begin
    s_clkdiv_n = s_clkdiv;
    s_hdp_n    = s_hdp;
    s_hndp_n   = s_hndp;
    s_vdp_n    = s_vdp;
    s_vndp_n   = s_vndp;
    div_n      = '0;
    hcnt_n     = '0;
    vcnt_n     = '0;
    if (!active || fend) begin
      s_clkdiv_n = bus.CLKDIV;
      s_hdp_n    = bus.HDP;
      s_hndp_n   = bus.HNDP;
      s_vdp_n    = bus.VDP;
      s_vndp_n   = bus.VNDP;
    end
    if (active) begin
      div_n  = (div == s_clkdiv) ? '0 : div + 1'b1;
      hcnt_n = hcnt;
      vcnt_n = vcnt;
      if (ptick) begin
        hcnt_n = le ? '0 : hcnt + 1'b1;
        if (le)
          vcnt_n = vlast ? '0 : vcnt + 1'b1;
      end
    end

    htot_n  = {1'b0, s_hdp_n} + {1'b0, s_hndp_n};
    vtot_n  = {1'b0, s_vdp_n} + {1'b0, s_vndp_n};
    le_n    = (htot_n == '0) || ({1'b0, hcnt_n} == htot_n - 1'b1);
    vlast_n = (vtot_n == '0) || ({1'b0, vcnt_n} == vtot_n - 1'b1);
    ptick_n = (div_n == s_clkdiv_n);
    fend_n  = ptick_n && le_n && vlast_n;

    // Sync width is clamped to the blanking interval
    hsw_n = ({1'b0, s_hndp_n} < HSW_W) ? {1'b0, s_hndp_n} : HSW_W;
    vsw_n = ({1'b0, s_vndp_n} < VSW_W) ? {1'b0, s_vndp_n} : VSW_W;
    de_n  = (hcnt_n < s_hdp_n) && (vcnt_n < s_vdp_n);
    hs_n  = (hcnt_n >= s_hdp_n) && ({1'b0, hcnt_n} < {1'b0, s_hdp_n} + hsw_n);
    vs_n  = (vcnt_n >= s_vdp_n) && ({1'b0, vcnt_n} < {1'b0, s_vdp_n} + vsw_n);
  end

  // Register stage: reset and EN=0 both park the generator in the idle state
  always_ff @(posedge PCLK) begin
    if (PRESET || !bus.EN) begin
      active   <= 1'b0;
      div      <= '0;
      s_clkdiv <= '0;
      s_hdp    <= '0;
      s_hndp   <= '0;
      s_vdp    <= '0;
      s_vndp   <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      ptick    <= 1'b0;
      le       <= 1'b0;
      vlast    <= 1'b0;
      de       <= 1'b0;
      fend     <= 1'b0;
      hsync    <= ~SYNC_ACT;
      vsync    <= ~SYNC_ACT;
    end else begin
      active   <= 1'b1;
      div      <= div_n;
      s_clkdiv <= s_clkdiv_n;
      s_hdp    <= s_hdp_n;
      s_hndp   <= s_hndp_n;
      s_vdp    <= s_vdp_n;
      s_vndp   <= s_vndp_n;
      hcnt     <= hcnt_n;
      vcnt     <= vcnt_n;
      ptick    <= ptick_n;
      le       <= le_n;
      vlast    <= vlast_n;
      de       <= de_n;
      fend     <= fend_n;
      hsync    <= hs_n ? SYNC_ACT : ~SYNC_ACT;
      vsync    <= vs_n ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign bus.PTICK = ptick;
  assign bus.HCNT  = hcnt;
  assign bus.VCNT  = vcnt;
  assign bus.DE    = de;
  assign bus.HSYNC = hsync;
  assign bus.VSYNC = vsync;
  assign bus.FEND  = fend;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: one instance with 1-pixel/1-line syncs,
// a second with HSW=4 for sync-width clamping.
module tb_video_timing_gen;
  logic pclk;
  logic preset;
  logic sel;

  video_timing_gen_if #(.CW(12), .DW(8)) bus_a ();
  video_timing_gen_if #(.CW(12), .DW(8)) bus_b ();

  video_timing_gen #(.CW(12), .DW(8), .HSW(1), .VSW(1), .SYNC_POL(0)) u_dut_a (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus_a.slave)
  );

  video_timing_gen #(.CW(12), .DW(8), .HSW(4), .VSW(2), .SYNC_POL(0)) u_dut_b (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus_b.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        m_ptick, m_de, m_hsync, m_vsync, m_fend;
  logic [11:0] m_hcnt, m_vcnt;

  always_comb begin
    m_ptick = sel ? bus_b.PTICK : bus_a.PTICK;
    m_hcnt  = sel ? bus_b.HCNT  : bus_a.HCNT;
    m_vcnt  = sel ? bus_b.VCNT  : bus_a.VCNT;
    m_de    = sel ? bus_b.DE    : bus_a.DE;
    m_hsync = sel ? bus_b.HSYNC : bus_a.HSYNC;
    m_vsync = sel ? bus_b.VSYNC : bus_a.VSYNC;
    m_fend  = sel ? bus_b.FEND  : bus_a.FEND;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Window statistics
  int w_de, w_fend, w_fend_at, w_pt, w_bad_pt, w_hs, w_bad_hs, w_vs, w_bad_vs, w_h0, w_nz;

  task automatic run_win(input int n, input int chg_at, input int ptmod,
                         input int hs_at, input int vs_at);
    w_de = 0; w_fend = 0; w_fend_at = 0; w_pt = 0; w_bad_pt = 0;
    w_hs = 0; w_bad_hs = 0; w_vs = 0; w_bad_vs = 0; w_h0 = 0; w_nz = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge pclk);
      if (m_de) w_de++;
      if (m_fend) begin w_fend++; w_fend_at = i; end
      if (m_ptick) w_pt++;
      if (m_ptick != ((i % ptmod) == 0)) w_bad_pt++;
      if (m_hsync == 1'b0) begin w_hs++; if (int'(m_hcnt) != hs_at) w_bad_hs++; end
      if (m_vsync == 1'b0) begin w_vs++; if (int'(m_vcnt) != vs_at) w_bad_vs++; end
      if (m_hcnt == 0) w_h0++;
      if (m_hcnt != 0 || m_vcnt != 0) w_nz++;
      if (i == chg_at) bus_a.HDP = 12'd5;
    end
  endtask

  task automatic wait_fend(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge pclk);
      if (m_fend) begin seen = 1'b1; break; end
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ptick"}, int'(m_ptick), 0);
    chk({tag, "_hcnt"},  int'(m_hcnt),  0);
    chk({tag, "_vcnt"},  int'(m_vcnt),  0);
    chk({tag, "_de"},    int'(m_de),    0);
    chk({tag, "_fend"},  int'(m_fend),  0);
    chk({tag, "_hsync"}, int'(m_hsync), 1);
    chk({tag, "_vsync"}, int'(m_vsync), 1);
  endtask

  initial begin
    int n;
    bit found;
    sel = 1'b0;
    preset = 1'b1;
    bus_a.EN = 1'b0; bus_a.CLKDIV = 8'd0;
    bus_a.HDP = 12'd4; bus_a.HNDP = 12'd2; bus_a.VDP = 12'd3; bus_a.VNDP = 12'd2;
    bus_b.EN = 1'b0; bus_b.CLKDIV = 8'd0;
    bus_b.HDP = 12'd4; bus_b.HNDP = 12'd1; bus_b.VDP = 12'd3; bus_b.VNDP = 12'd2;
    repeat (3) @(negedge pclk);
    chk_idle("reset");

    // Basic frame
    preset = 1'b0;
    bus_a.EN = 1'b1;
    bus_b.EN = 1'b1;
    wait_fend("t1_fend_timeout", 100);
    run_win(30, 0, 1, 4, 3);
    chk("t1_de_cycles",   w_de, 12);
    chk("t1_fend_count",  w_fend, 1);
    chk("t1_fend_pos",    w_fend_at, 30);
    chk("t1_line_starts", w_h0, 5);
    chk("t1_hsync_count", w_hs, 5);
    chk("t1_hsync_pos",   w_bad_hs, 0);
    chk("t1_vsync_count", w_vs, 6);
    chk("t1_vsync_pos",   w_bad_vs, 0);

    // Divider
    bus_a.CLKDIV = 8'd2;
    wait_fend("t2_fend_timeout", 200);
    run_win(90, 0, 3, 4, 3);
    chk("t2_ptick_count", w_pt, 30);
    chk("t2_ptick_phase", w_bad_pt, 0);
    chk("t2_hcnt0_cycles", w_h0, 15);
    chk("t2_fend_pos",    w_fend_at, 90);
    chk("t2_de_cycles",   w_de, 36);

    // Mid-frame write: HDP 4->5 at VCNT=1 takes effect only in the next frame
    bus_a.CLKDIV = 8'd0;
    wait_fend("t3_fend_timeout", 200);
    run_win(30, 7, 1, 4, 3);
    chk("t3_old_de_cycles", w_de, 12);
    chk("t3_old_fend_pos",  w_fend_at, 30);
    run_win(35, 0, 1, 5, 3);
    chk("t3_new_de_cycles", w_de, 15);
    chk("t3_new_fend_pos",  w_fend_at, 35);
    chk("t3_new_lines",     w_h0, 5);
    chk("t3_new_hsync_pos", w_bad_hs, 0);
    chk("t3_new_vsync",     w_vs, 7);

    // Sync clamp on the HSW=4 instance
    sel = 1'b1;
    wait_fend("t4_fend_timeout", 100);
    run_win(25, 0, 1, 4, 3);
    chk("t4_hsync_count", w_hs, 5);
    chk("t4_hsync_pos",   w_bad_hs, 0);
    chk("t4_fend_pos",    w_fend_at, 25);
    bus_b.HNDP = 12'd0;
    wait_fend("t4b_fend_timeout", 100);
    run_win(20, 0, 1, 4, 3);
    chk("t4_nohsync_count", w_hs, 0);
    chk("t4_nohsync_fend",  w_fend_at, 20);
    chk("t4_nohsync_de",    w_de, 12);
    sel = 1'b0;

    // Reset mid-frame at HCNT=3, VCNT=2
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (m_hcnt == 3 && m_vcnt == 2) begin found = 1'b1; break; end
    end
    chk("t5_find_pos", int'(found), 1);
    preset = 1'b1;
    @(negedge pclk);
    chk_idle("t5_rst");
    n = 0;
    repeat (4) begin @(negedge pclk); if (m_fend) n++; end
    chk("t5_no_fend", n, 0);
    preset = 1'b0;
    bus_a.EN = 1'b0;
    bus_a.CLKDIV = 8'd2;
    repeat (2) @(negedge pclk);
    chk("t5_en0_ptick", int'(m_ptick), 0);
    bus_a.EN = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge pclk);
      if (m_ptick) begin n = i; break; end
    end
    chk("t5_first_ptick", n, 3);
    chk("t5_first_hcnt", int'(m_hcnt), 0);
    chk("t5_first_vcnt", int'(m_vcnt), 0);

    // Zero totals
    bus_a.EN = 1'b0;
    bus_a.CLKDIV = 8'd0;
    bus_a.HDP = 12'd0; bus_a.HNDP = 12'd0; bus_a.VDP = 12'd0; bus_a.VNDP = 12'd0;
    @(negedge pclk);
    bus_a.EN = 1'b1;
    run_win(10, 0, 1, 0, 0);
    chk("t6_counts_zero", w_nz, 0);
    chk("t6_de_cycles",   w_de, 0);
    chk("t6_ptick_count", w_pt, 10);
    chk("t6_fend_count",  w_fend, 10);
    chk("t6_hsync_count", w_hs, 0);
    chk("t6_vsync_count", w_vs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
